// File: rtl/booth_seq_ctrl_pkg.sv
// Shared types for the sequential Booth multiplier controller: FSM states
// and the radix-2 Booth operation decoded from the two low Q bits.
package booth_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2
    } booth_op_t;

    // Radix-2 Booth recoding: 01 -> +M, 10 -> -M, 00/11 -> shift only.
    function automatic booth_op_t booth_decode(input logic [1:0] qb);
        case (qb)
            2'b01:   return OP_ADD;
            2'b10:   return OP_SUB;
            default: return OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_seq_ctrl_if.sv
// Request/response bundle of the Booth multiplier controller.
// master drives start and operands; slave (the controller) returns
// busy, done and the 2N-bit signed product.
interface booth_seq_ctrl_if #(
    parameter int N = 4
);
    logic             start;
    logic [N-1:0]     multiplicand;
    logic [N-1:0]     multiplier;
    logic             busy;
    logic             done;
    logic [2*N-1:0]   product;

    modport master (
        output start, multiplicand, multiplier,
        input  busy, done, product
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output busy, done, product
    );
endinterface

// File: rtl/booth_seq_ctrl_step.sv
// booth_step: one combinational radix-2 Booth iteration on (N+1)-bit A/Q/M.
// Adds or subtracts M into A as selected by Q[1:0], then arithmetic-shifts
// the concatenation {A,Q} right by one bit.
module booth_step
    import booth_seq_ctrl_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N:0] a,
    input  logic [N:0] q,
    input  logic [N:0] m,
    output logic [N:0] a_nx,
    output logic [N:0] q_nx
);
    booth_op_t  op;
    logic [N:0] sum;

    assign op = booth_decode(q[1:0]);

    // Partial-product update selected by the Booth recoding of Q[1:0].
    always_comb begin
        case (op)
            OP_ADD:  sum = a + m;
            OP_SUB:  sum = a - m;
            default: sum = a;
        endcase
    end

    // Arithmetic shift of {sum, q}: sign of A replicates, A LSB enters Q MSB.
    assign a_nx = {sum[N], sum[N:1]};
    assign q_nx = {sum[0], q[N:1]};

endmodule

// File: rtl/booth_seq_ctrl.sv
// booth_seq_ctrl: sequential radix-2 Booth multiplier controller.
// Accepts an operand pair on start, iterates booth_step once per clock and
// returns the signed 2N-bit product with a one-cycle done pulse.
// Optional feature macro: BOOTH_EARLY_TERM_EN -- when the remaining Q bits
// are uniform, all remaining shift-only steps collapse into one edge.
module booth_seq_ctrl
    import booth_seq_ctrl_pkg::*;
#(
    parameter int N = 4
) (
    input  logic               clk,
    input  logic               rst,
    booth_seq_ctrl_if.slave    bus
);
    localparam int CNT_W = $clog2(N + 1);

    state_t             state;
    logic [N:0]         a_reg;
    logic [N:0]         q_reg;
    logic [N:0]         m_reg;
    logic [CNT_W-1:0]   cnt;
    logic               busy_reg;
    logic               done_reg;
    logic [2*N-1:0]     prod_reg;

    logic [N:0]         step_a;
    logic [N:0]         step_q;
    logic [N:0]         a_nx;
    logic [N:0]         q_nx;
    logic               last;

    booth_step #(.N(N)) u_step (
        .a    (a_reg),
        .q    (q_reg),
        .m    (m_reg),
        .a_nx (step_a),
        .q_nx (step_q)
    );

`ifdef BOOTH_EARLY_TERM_EN
    logic [N:0]         uni_mask;
    logic [N:0]         q_masked;
    logic               uniform;
    logic [2*N+1:0]     aq_sh;

    // Unprocessed bits are Q[cnt:0]; if they are all equal, every remaining
    // step is shift-only and the whole tail is one arithmetic shift by cnt.
    always_comb begin
        uni_mask = '0;
        for (int i = 0; i <= N; i++) begin
            uni_mask[i] = (i <= int'(cnt));
        end
        q_masked = q_reg & uni_mask;
        uniform  = (q_masked == '0) || (q_masked == uni_mask);
        aq_sh    = $signed({a_reg, q_reg}) >>> cnt;
    end
`endif

    // Next A/Q for a RUN edge and whether this edge finishes the multiply.
    always_comb begin
        a_nx = step_a;
        q_nx = step_q;
        last = (cnt == CNT_W'(1));
`ifdef BOOTH_EARLY_TERM_EN
        if (uniform) begin
            {a_nx, q_nx} = aq_sh;
            last         = 1'b1;
        end
`endif
    end

    // Controller FSM: owns A/Q/M, the step counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_reg    <= '0;
            q_reg    <= '0;
            m_reg    <= '0;
            cnt      <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
            prod_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        m_reg    <= {bus.multiplicand[N-1], bus.multiplicand};
                        a_reg    <= '0;
                        q_reg    <= {bus.multiplier, 1'b0};
                        cnt      <= CNT_W'(N);
                        busy_reg <= 1'b1;
                        state    <= RUN;
                    end else begin
                        state    <= IDLE;
                    end
                end
                RUN: begin
                    a_reg <= a_nx;
                    q_reg <= q_nx;
                    if (last) begin
                        // A[N] is only a guard bit; the product fits in 2N bits.
                        prod_reg <= {a_nx[N-1:0], q_nx[N:1]};
                        busy_reg <= 1'b0;
                        done_reg <= 1'b1;
                        state    <= DONE;
                    end else begin
                        cnt      <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    busy_reg <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_reg;
    assign bus.done    = done_reg;
    assign bus.product = prod_reg;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Self-checking bench for booth_seq_ctrl: a cycle-level arithmetic model
// (countdown + signed product) checked every cycle, plus directed vectors
// with literal products and latencies.
module tb_booth_seq_ctrl;
    localparam int N = 4;

`ifdef BOOTH_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    booth_seq_ctrl_if #(.N(N)) bus ();

    booth_seq_ctrl #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int errors = 0;
    int checks = 0;
    bit armed  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Edges from accept to done: N, or earlier once the unprocessed
    // multiplier bits (with the appended 0) are all equal.
    function automatic int exp_lat(input logic [N-1:0] mp);
        logic [N:0] qe;
        logic [N:0] t;
        int         w;
        qe = {mp, 1'b0};
        if (ET) begin
            for (int k = 0; k <= N - 2; k++) begin
                t = qe >> k;
                w = N + 1 - k;
                if (t == '0 || int'(t) == (1 << w) - 1) return k + 1;
            end
        end
        return N;
    endfunction

    function automatic logic [2*N-1:0] prod_of(input logic [N-1:0] a, input logic [N-1:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p[2*N-1:0];
    endfunction

    // Model: remaining-edge countdown and pending product.
    int             rem = 0;
    logic [2*N-1:0] pend = '0;
    logic [2*N-1:0] m_prod = '0;
    bit             m_busy = 1'b0;
    bit             m_done = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            rem = 0; m_busy = 1'b0; m_done = 1'b0; m_prod = '0;
        end else begin
            m_done = 1'b0;
            if (rem > 0) begin
                rem--;
                if (rem == 0) begin
                    m_done = 1'b1;
                    m_prod = pend;
                end
            end else if (bus.start) begin
                rem  = exp_lat(bus.multiplier);
                pend = prod_of(bus.multiplicand, bus.multiplier);
            end
            m_busy = (rem > 0);
        end
        armed = 1'b1;
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (armed) begin
            chk("busy",    32'(bus.busy),    32'(m_busy));
            chk("done",    32'(bus.done),    32'(m_done));
            chk("product", 32'(bus.product), 32'(m_prod));
        end
    end

    // Called just after the accept edge; returns edges until done is seen.
    task automatic wait_done(input bit scramble, output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
            if (scramble) begin
                bus.multiplicand = 4'($urandom);
                bus.multiplier   = 4'($urandom);
            end
            @(negedge clk);
        end while (!bus.done && lat < 20);
    endtask

    task automatic mul(input string name, input logic [N-1:0] mc, input logic [N-1:0] mp,
                       input logic [2*N-1:0] exp_p, input int exp_l, input bit scramble);
        int lat;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.multiplicand = mc; bus.multiplier = mp;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(scramble, lat);
        chk({name, "_lat"},  32'(lat),         32'(exp_l));
        chk({name, "_prod"}, 32'(bus.product), 32'(exp_p));
    endtask

    int lat;
    int dones;

    initial begin
        bus.start = 1'b0; bus.multiplicand = '0; bus.multiplier = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset during RUN aborts; no done afterwards.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.multiplicand = 4'd3; bus.multiplier = 4'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy),    32'd0);
        chk("rst_done", 32'(bus.done),    32'd0);
        chk("rst_prod", 32'(bus.product), 32'd0);
        dones = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        chk("rst_no_done", 32'(dones), 32'd0);

        // Basic and boundary products.
        mul("3x5",   4'd3,  4'd5,  8'h0F, 4, 1'b0);
        mul("m8xm8", 4'h8,  4'h8,  8'h40, 4, 1'b0);
        mul("m8x7",  4'h8,  4'd7,  8'hC8, 4, 1'b0);
        mul("m1xm1", 4'hF,  4'hF,  8'h01, ET ? 2 : 4, 1'b0);

        // Operands scrambled every cycle during RUN.
        mul("7xm6_scr", 4'd7, 4'hA, 8'hD6, 4, 1'b1);

        // start mid-RUN ignored; start held in DONE accepted back-to-back.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.multiplicand = 4'd3; bus.multiplier = 4'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.multiplicand = 4'd7; bus.multiplier = 4'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(1'b0, lat);
        chk("ign_lat",  32'(lat + 2),      32'd4);
        chk("ign_prod", 32'(bus.product),  32'h0F);
        bus.start = 1'b1; bus.multiplicand = 4'h8; bus.multiplier = 4'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        chk("b2b_busy", 32'(bus.busy), 32'd1);
        wait_done(1'b0, lat);
        chk("b2b_lat",  32'(lat),          32'd4);
        chk("b2b_prod", 32'(bus.product),  32'hC8);

        // Early-termination vectors (full latency without the feature).
        mul("6x0",  4'd6, 4'd0, 8'h00, ET ? 1 : 4, 1'b0);
        mul("6xm1", 4'd6, 4'hF, 8'hFA, ET ? 2 : 4, 1'b0);
        mul("5xm3", 4'd5, 4'hD, 8'hF1, 4, 1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
